// File: rtl/mux_seven_seg_driver.sv
// rtl/mux_seven_seg_driver.sv - time-multiplexed common-anode seven-segment driver
// Frame-synchronous value commit, per-digit dead time, blanking and leading-zero suppression.
module mux_seven_seg_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  output logic [0:6]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] PC_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    pc;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp;
  logic                pending;

  logic                pc_last;
  logic                wrap;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   zero_from;
  logic                acc;
  logic                dark;
  logic [DIGITS-1:0]   an_on;

  function automatic logic [0:6] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign pc_last = (pc == PC_LAST);
  assign wrap    = pc_last && (idx == IDX_LAST);
  assign nib     = disp[idx*4 +: 4];
  assign an_on   = ~(DIGITS'(1) << idx);

  // zero_from[i]: nibbles i..DIGITS-1 of the committed value are all zero
  always_comb begin
    acc       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (disp[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end
  end

  assign dark = blank_mask[idx] | (lz_en & (idx != '0) & zero_from[idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      seg        <= '1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      pc <= pc_last ? '0 : pc + 1'b1;
      if (pc_last)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // a load on the wrap edge bypasses the shadow so it lands in the next frame
      if (load) begin
        if (wrap) begin
          disp    <= value;
          pending <= 1'b0;
        end else begin
          shadow  <= value;
          pending <= 1'b1;
        end
      end else if (wrap && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end

      frame_tick <= wrap;

      if (pc == '0 || dark) begin
        an  <= '1;
        seg <= '1;
      end else begin
        an  <= an_on;
        seg <= glyph(nib);
      end
    end
  end

endmodule

// File: tb/tb_mux_seven_seg_driver.sv
// tb/tb_mux_seven_seg_driver.sv - self-checking bench for mux_seven_seg_driver
// Cycle-indexed behavioural model plus directed literal checks and random stimulus.
module tb_mux_seven_seg_driver;

  localparam int D = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_en = 1'b0;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  mux_seven_seg_driver #(.DIGITS(D), .PRESCALE(P), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .blank_mask(blank_mask), .lz_en(lz_en),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: slot position is derived from the edge count since reset
  int unsigned mt;
  logic [15:0] m_shadow, m_disp;
  logic        m_pending;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_ft;

  int          m_pc, m_idx;
  bit          m_wrap, m_lit;
  logic [3:0]  m_nib;

  always_comb begin
    m_pc   = int'(mt % P);
    m_idx  = int'((mt / P) % D);
    m_wrap = (m_pc == P - 1) && (m_idx == D - 1);
    m_nib  = 4'((m_disp >> (4 * m_idx)) & 16'hF);
    m_lit  = (m_pc != 0) && !blank_mask[m_idx] &&
             !(lz_en && m_idx > 0 && (m_disp >> (4 * m_idx)) == 16'd0);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mt <= 0; m_shadow <= '0; m_disp <= '0; m_pending <= 1'b0;
      e_seg <= 7'h7F; e_an <= 4'hF; e_ft <= 1'b0;
    end else begin
      e_ft  <= m_wrap;
      e_an  <= m_lit ? 4'(~(4'b0001 << m_idx)) : 4'hF;
      e_seg <= m_lit ? GLYPH[m_nib] : 7'h7F;
      if (load) begin
        if (m_wrap) begin m_disp <= value; m_pending <= 1'b0; end
        else begin m_shadow <= value; m_pending <= 1'b1; end
      end else if (m_wrap && m_pending) begin
        m_disp <= m_shadow; m_pending <= 1'b0;
      end
      mt <= mt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("seg_vs_model", 32'(seg), 32'(e_seg));
      chk("an_vs_model", 32'(an), 32'(e_an));
      chk("frame_tick_vs_model", 32'(frame_tick), 32'(e_ft));
    end
  end

  task automatic goto(input int unsigned k);
    int guard;
    guard = 0;
    while (mt < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("goto_cycle", mt, k);
  endtask

  task automatic lit(input string name, input logic [6:0] s, input logic [3:0] a);
    chk({name, "_seg"}, 32'(seg), 32'(s));
    chk({name, "_an"}, 32'(an), 32'(a));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1; cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    goto(1);  lit("reset_dead", 7'h7F, 4'b1111);
    goto(2);  lit("first_digit0", 7'b0000001, 4'b1110);
    goto(15); chk("ft_before", 32'(frame_tick), 0);
    goto(16); chk("ft_first", 32'(frame_tick), 1);
    goto(17); chk("ft_after", 32'(frame_tick), 0);

    goto(19); pulse_load(16'h12AF);
    goto(30); lit("old_frame_d3", 7'b0000001, 4'b0111);
    goto(34); lit("12AF_d0", 7'b0111000, 4'b1110);
    goto(38); lit("12AF_d1", 7'b0001000, 4'b1101);
    goto(42); lit("12AF_d2", 7'b0010010, 4'b1011);
    goto(46); lit("12AF_d3", 7'b1001111, 4'b0111);

    goto(50); pulse_load(16'h1111);
    goto(55); pulse_load(16'h2222);
    goto(62); lit("pre_commit_d3", 7'b1001111, 4'b0111);
    goto(66); lit("last_wins_d0", 7'b0010010, 4'b1110);
    goto(78); lit("last_wins_d3", 7'b0010010, 4'b0111);

    lz_en = 1'b1;
    goto(82);  pulse_load(16'h0050);
    goto(98);  lit("lz_d0", 7'b0000001, 4'b1110);
    goto(102); lit("lz_d1", 7'b0100100, 4'b1101);
    goto(106); lit("lz_d2_dark", 7'h7F, 4'b1111);
    goto(110); lit("lz_d3_dark", 7'h7F, 4'b1111);
    goto(114); pulse_load(16'h0000);
    goto(130); lit("lz_zero_d0", 7'b0000001, 4'b1110);
    goto(134); lit("lz_zero_d1_dark", 7'h7F, 4'b1111);

    lz_en = 1'b0; blank_mask = 4'b0100;
    goto(146); pulse_load(16'h8888);
    goto(162); lit("blank_d0", 7'b0000000, 4'b1110);
    goto(170); lit("blank_d2_dark", 7'h7F, 4'b1111);
    goto(174); lit("blank_d3", 7'b0000000, 4'b0111);
    blank_mask = 4'b0000;

    goto(191); pulse_load(16'h3C5E);
    goto(194); lit("wrap_load_d0", 7'b0110000, 4'b1110);
    goto(198); lit("wrap_load_d1", 7'b0100100, 4'b1101);

    goto(200); pulse_load(16'h9999);
    goto(203);
    #3 reset = 1'b1;
    #1 lit("async_reset", 7'h7F, 4'b1111);
    chk("async_reset_ft", 32'(frame_tick), 0);
    @(negedge clk);
    reset = 1'b0;
    goto(2);  lit("post_reset_d0", 7'b0000001, 4'b1110);
    goto(18); lit("pending_discarded", 7'b0000001, 4'b1110);

    for (int c = 0; c < 3000; c++) begin
      logic [15:0] v;
      @(negedge clk);
      v = 16'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(2) == 0) v[4*i +: 4] = 4'h0;
      value      = v;
      load       = ($urandom_range(7) == 0);
      blank_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      lz_en      = ($urandom_range(1) == 0);
      reset      = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
